// File: rtl/orbit_vga_renderer.sv
// Orbit plot display: VGA raster generator that draws a double-buffered object
// dot and a fixed Earth marker, refreshing the dot position only between frames.
module orbit_vga_renderer #(
  parameter int DOT_SIZE   = 4,
  parameter int EARTH_X    = 316,
  parameter int EARTH_Y    = 236,
  parameter int EARTH_SIZE = 8,
  // Raster geometry in pixel ticks / lines; defaults give 640x480@60 at 25 MHz.
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] plot_x,
  input  logic [9:0] plot_y,
  input  logic       plot_valid,
  output logic       plot_ready,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       frame_tick
);

  localparam logic [10:0] H_VIS     = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS     = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST    = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] DOT       = 11'(DOT_SIZE);
  localparam logic [10:0] EX_LO     = 11'(EARTH_X);
  localparam logic [10:0] EX_HI     = 11'(EARTH_X + EARTH_SIZE);
  localparam logic [10:0] EY_LO     = 11'(EARTH_Y);
  localparam logic [10:0] EY_HI     = 11'(EARTH_Y + EARTH_SIZE);

  logic       pix_en_reg;
  logic [9:0] h_cnt_reg;
  logic [9:0] v_cnt_reg;
  logic [9:0] h_cnt_next;
  logic [9:0] v_cnt_next;

  logic [9:0] shadow_x_reg;
  logic [9:0] shadow_y_reg;
  logic       shadow_ok_reg;
  logic       shadow_full_reg;
  logic [9:0] active_x_reg;
  logic [9:0] active_y_reg;
  logic       active_ok_reg;

  logic [7:0] r_reg;
  logic [7:0] g_reg;
  logic [7:0] b_reg;
  logic       hs_reg;
  logic       vs_reg;
  logic       frame_tick_reg;

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] ax_ext;
  logic [10:0] ay_ext;
  logic        visible;
  logic        in_dot;
  logic        in_earth;
  logic        hs_next;
  logic        vs_next;
  logic [7:0]  r_next;
  logic [7:0]  g_next;
  logic [7:0]  b_next;
  logic        frame_start;
  logic        capture;
  logic        transfer;
  logic        plot_in_range;

  // Raster counter successor values.
  always_comb begin
    h_ext      = {1'b0, h_cnt_reg};
    v_ext      = {1'b0, v_cnt_reg};
    h_cnt_next = h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_ext == H_LAST) begin
      h_cnt_next = '0;
      if (v_ext == V_LAST) begin
        v_cnt_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + 10'd1;
      end
    end
  end

  // Pixel colour and syncs for the current counter position; 11-bit compares keep
  // a dot near the right/bottom edge clipped instead of wrapping.
  always_comb begin
    ax_ext   = {1'b0, active_x_reg};
    ay_ext   = {1'b0, active_y_reg};
    visible  = (h_ext < H_VIS) && (v_ext < V_VIS);
    in_dot   = active_ok_reg &&
               (h_ext >= ax_ext) && (h_ext < ax_ext + DOT) &&
               (v_ext >= ay_ext) && (v_ext < ay_ext + DOT);
    in_earth = (h_ext >= EX_LO) && (h_ext < EX_HI) &&
               (v_ext >= EY_LO) && (v_ext < EY_HI);
    hs_next  = !((h_ext >= H_SYNC_LO) && (h_ext < H_SYNC_HI));
    vs_next  = !((v_ext >= V_SYNC_LO) && (v_ext < V_SYNC_HI));
    r_next   = 8'h00;
    g_next   = 8'h00;
    b_next   = 8'h00;
    if (visible) begin
      if (in_dot) begin
        r_next = 8'hFF;
        g_next = 8'hFF;
        b_next = 8'hFF;
      end else if (in_earth) begin
        b_next = 8'hFF;
      end
    end
  end

  always_comb begin
    frame_start   = pix_en_reg && (h_cnt_reg == '0) && (v_ext == V_VIS);
    capture       = plot_valid && !shadow_full_reg;
    transfer      = frame_start && shadow_full_reg;
    plot_in_range = ({1'b0, plot_x} < H_VIS) && ({1'b0, plot_y} < V_VIS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_reg <= 1'b0;
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
    end else begin
      pix_en_reg <= !pix_en_reg;
      if (pix_en_reg) begin
        h_cnt_reg <= h_cnt_next;
        v_cnt_reg <= v_cnt_next;
      end
    end
  end

  // Syncs and colour share one register stage so they stay aligned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_reg          <= '0;
      g_reg          <= '0;
      b_reg          <= '0;
      hs_reg         <= 1'b1;
      vs_reg         <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_start;
      if (pix_en_reg) begin
        r_reg  <= r_next;
        g_reg  <= g_next;
        b_reg  <= b_next;
        hs_reg <= hs_next;
        vs_reg <= vs_next;
      end
    end
  end

  // Capture and transfer are exclusive: capture needs an empty shadow, transfer a full one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x_reg    <= '0;
      shadow_y_reg    <= '0;
      shadow_ok_reg   <= 1'b0;
      shadow_full_reg <= 1'b0;
      active_x_reg    <= '0;
      active_y_reg    <= '0;
      active_ok_reg   <= 1'b0;
    end else begin
      if (capture) begin
        shadow_x_reg    <= plot_x;
        shadow_y_reg    <= plot_y;
        shadow_ok_reg   <= plot_in_range;
        shadow_full_reg <= 1'b1;
      end else if (transfer) begin
        active_x_reg    <= shadow_x_reg;
        active_y_reg    <= shadow_y_reg;
        active_ok_reg   <= shadow_ok_reg;
        shadow_full_reg <= 1'b0;
      end
    end
  end

  assign plot_ready = !shadow_full_reg;
  assign VGA_R      = r_reg;
  assign VGA_G      = g_reg;
  assign VGA_B      = b_reg;
  assign VGA_HS     = hs_reg;
  assign VGA_VS     = vs_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: doc/orbit_vga_renderer.md
Name: orbit_vga_renderer

Overview:
- Display-side consumer of the orbit plot interface: accepts object pixel coordinates over a valid/ready handshake.
- Generates 640x480@60 Hz VGA timing from the 50 MHz clock and scans out a black frame with the object drawn as a white square and a fixed blue Earth marker at screen centre.
- Accepted coordinates are double-buffered so that the displayed position changes only at frame boundaries (no tearing).

Parameters:
- DOT_SIZE, 4, object square edge length in pixels.
- EARTH_X, 316, left column of the Earth marker.
- EARTH_Y, 236, top row of the Earth marker.
- EARTH_SIZE, 8, Earth marker edge length in pixels.

Ports:
- clock  input  1  50 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- plot_x  input  10  object column, valid range 0..639.
- plot_y  input  10  object row, valid range 0..479.
- plot_valid  input  1  plot coordinate request.
- plot_ready  output  1  shadow buffer empty; request accepted when plot_valid && plot_ready.
- VGA_R  output  8  red.
- VGA_G  output  8  green.
- VGA_B  output  8  blue.
- VGA_HS  output  1  horizontal sync, active low.
- VGA_VS  output  1  vertical sync, active low.
- frame_tick  output  1  one-clock pulse at the start of vertical blanking.

Behaviour:
- Reset (async assert, sync release):
  - h_cnt, v_cnt, pix_en phase = 0.
  - plot_ready = 1, shadow empty, active position invalid (dot hidden).
  - VGA_R/G/B = 0, VGA_HS = 1, VGA_VS = 1, frame_tick = 0.
- pix_en toggles every clock (25 MHz tick); first pix_en = 1 occurs on the second clock after reset release. Counters advance only when pix_en = 1.
- Horizontal timing: h_cnt 0..799.
  - 0..639 visible, 640..655 front porch, 656..751 sync, 752..799 back porch.
  - Wraps 799 -> 0 and increments v_cnt.
- Vertical timing: v_cnt 0..524.
  - 0..479 visible, 480..489 front porch, 490..491 sync, 492..524 back porch.
  - Wraps 524 -> 0.
- Output pipeline: HS, VS and RGB are registered from the counter state on the pix_en tick, giving 1 pixel tick (2 clocks) of latency. All three are delayed equally, so syncs stay aligned with pixels.
  - VGA_HS = 0 iff h_cnt in 656..751.
  - VGA_VS = 0 iff v_cnt in 490..491.
- Colour selection, in priority order:
  1. Outside the visible area: RGB = 0.
  2. Object pixel (active position valid, h_cnt in [ax, ax+DOT_SIZE-1], v_cnt in [ay, ay+DOT_SIZE-1]): R = G = B = 8'hFF.
  3. Earth pixel (h_cnt in [EARTH_X, EARTH_X+EARTH_SIZE-1], v_cnt in [EARTH_Y, EARTH_Y+EARTH_SIZE-1]): R = G = 0, B = 8'hFF.
  4. Otherwise RGB = 0.
  - The object overrides Earth where they overlap.
  - Range compares use 11-bit arithmetic so ax+DOT_SIZE cannot wrap. A dot near the right or bottom edge is clipped, never wrapped to the opposite edge.
- Handshake:
  - On plot_valid && plot_ready: shadow <= {plot_x, plot_y}, shadow full, plot_ready drops on the next clock.
  - plot_valid while plot_ready = 0 is ignored. The requester holds its request and data until ready.
  - Out-of-range coordinates (plot_x >= 640 or plot_y >= 480) are accepted but mark the shadow invalid, which hides the dot once transferred.
- Frame boundary (pix_en tick with h_cnt = 0, v_cnt = 480):
  - frame_tick pulses for 1 clock.
  - If the shadow is full: active <= shadow (including its valid flag), shadow emptied, plot_ready = 1 on the next clock.
  - If the shadow is empty: the active position is retained, so the dot keeps its last position.
  - No capture can coincide with the transfer, because plot_ready = 0 whenever the shadow is full.
- At most one position update per frame. Excess requests stall via plot_ready.
- Reset asserted mid-frame: outputs go to reset values immediately and any pending shadow is discarded.

Test Plan:
1. Timing: release reset, run 2 frames -> HS low pulse 96 px ticks every 800; VS low exactly 2 lines (1600 px ticks) every 525 lines; frame_tick period 840000 clocks.
2. Plot (100,50) mid-frame -> plot_ready = 0 on the next clock; dot not visible until after the next frame_tick; the following frame shows RGB = FF for columns 100..103 on rows 50..53 and 0 at (104,50); plot_ready = 1 after the transfer.
3. Back-to-back: send (10,10), then hold plot_valid with (20,20) -> second request stalls until the frame boundary; frame N shows (10,10) and frame N+1 shows (20,20).
4. Edge clip: plot (638,478) -> white pixels only at columns 638..639, rows 478..479; column 0 and row 0 stay black.
5. Overlap and invalid: plot (318,238) -> white wins over blue at (318,238), blue at (316,236); then plot (700,10) -> dot hidden next frame, Earth marker still blue.
6. Async reset mid-frame with the shadow full -> VGA_HS = 1, VGA_VS = 1, RGB = 0 and plot_ready = 1 immediately; after release, no dot is drawn until a new plot is accepted.
